// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide unit controller.
//   - md_op operation codes (MULT..MTLO)
//   - FSM state encoding (IDLE, BUSY)
//   - latency counter width
//   - helper to classify arithmetic (busy-producing) operations
package mdu_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mult(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath.
// Ports:
//   md_op  [2:0]  in   operation code (mdu_pkg OP_*)
//   rs_val [31:0] in   rs operand (multiplicand / dividend)
//   rt_val [31:0] in   rt operand (multiplier / divisor)
//   hi_res [31:0] out  product[63:32] or remainder
//   lo_res [31:0] out  product[31:0] or quotient
//   div_zero      out  div/divu with a zero divisor
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] dvs;
    logic               ovf;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    always_comb begin
        prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};

        // Zero divisor and the signed min/-1 overflow both divide by 1 instead:
        // zero is discarded by the controller, and min/1 already gives the
        // architectural answer (quotient 0x80000000, remainder 0).
        ovf      = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF) && (md_op == OP_DIV);
        div_zero = (rt_val == 32'd0) && ((md_op == OP_DIV) || (md_op == OP_DIVU));
        dvs      = ((rt_val == 32'd0) || ovf) ? 32'd1 : rt_val;

        quo_s = $signed(rs_val) / $signed(dvs);
        rem_s = $signed(rs_val) % $signed(dvs);
        quo_u = rs_val / dvs;
        rem_u = rs_val % dvs;

        hi_res = 32'd0;
        lo_res = 32'd0;
        case (md_op)
            OP_MULT:  begin hi_res = prod_s[63:32];  lo_res = prod_s[31:0]; end
            OP_MULTU: begin hi_res = prod_u[63:32];  lo_res = prod_u[31:0]; end
            OP_DIV:   begin hi_res = rem_s;          lo_res = quo_s;        end
            OP_DIVU:  begin hi_res = rem_u;          lo_res = quo_u;        end
            default:  begin hi_res = 32'd0;          lo_res = 32'd0;        end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller, owns architectural HI/LO.
// Ports:
//   clk, reset (async, active-low)
//   start, md_op[2:0], rs_val[31:0], rt_val[31:0]  E-stage MDU instruction
//   d_md_use      D-stage instruction touches the MDU
//   cancel        (only with MDU_CANCEL_EN) abort / suppress from flush logic
//   busy          arithmetic op in flight
//   stall_req     hold PC/RegD, clear RegE
//   hi, lo        architectural HI/LO
// Build option: define MDU_CANCEL_EN to add the cancel input.
//
// state | meaning
// IDLE  | no op in flight; accepts arithmetic ops and mthi/mtlo
// BUSY  | counter running; result commits on the 1->0 edge
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
    logic        pend_wr_q, pend_wr_d;

    logic [31:0] hi_res, lo_res;
    logic        div_zero;
    logic        cancel_w;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    mdu_arith u_arith (
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi_res   (hi_res),
        .lo_res   (lo_res),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel_w) begin
                    if (is_arith(md_op)) begin
                        hi_pend_d = hi_res;
                        lo_pend_d = lo_res;
                        // A zero divisor still burns the full latency but never commits.
                        pend_wr_d = !div_zero;
                        cnt_d     = is_mult(md_op) ? cnt_t'(MULT_CYC) : cnt_t'(DIV_CYC);
                        state_d   = ST_BUSY;
                    end else if (md_op == OP_MTHI) begin
                        hi_d = rs_val;
                    end else if (md_op == OP_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            ST_BUSY: begin
                // Cancel outranks completion, so a cancelled op never commits.
                if (cancel_w) begin
                    cnt_d   = cnt_t'(0);
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                    if (cnt_q == cnt_t'(1)) begin
                        state_d = ST_IDLE;
                        if (pend_wr_q) begin
                            hi_d = hi_pend_q;
                            lo_d = lo_pend_q;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = cnt_t'(0);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= cnt_t'(0);
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_pend_q <= 32'd0;
            lo_pend_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    // Combinational so the hazard unit can stall in the same cycle the op issues.
    assign stall_req = d_md_use & (busy | (start & is_arith(md_op)));
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_md_use  (d_md_use),
`ifdef MDU_CANCEL_EN
        .cancel    (cancel),
`endif
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count busy cycles (bounded), then check latency and HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp,
                          input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        int n;
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk({tag, ".cycles"}, 32'(n), 32'(n_exp));
        chk({tag, ".hi"}, hi, hi_exp);
        chk({tag, ".lo"}, lo, lo_exp);
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0; d_md_use = 1'b0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        repeat (2) tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.stall", 32'(stall_req), 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        run_op("mult",  3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 3'd3, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("divu",  3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("multmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000);

        // Stall: asserted in the issue cycle and every busy cycle, clear when busy falls.
        d_md_use = 1'b1;
        start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
        #1;
        chk("stall.issue", 32'(stall_req), 32'd1);
        chk("stall.issue_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall.busy%0d", i), 32'(stall_req & busy), 32'd1);
            tick();
        end
        chk("stall.done", 32'(stall_req), 32'd0);
        chk("stall.done_busy", 32'(busy), 32'd0);
        start = 1'b1; md_op = 3'd4;
        #1;
        chk("stall.mthi", 32'(stall_req), 32'd0);
        start = 1'b0; d_md_use = 1'b0;

        // mthi then mtlo back to back.
        start = 1'b1; md_op = 3'd4; rs_val = 32'h1234_5678;
        tick();
        chk("mthi.hi", hi, 32'h1234_5678);
        chk("mthi.lo", lo, 32'd12);
        chk("mthi.busy", 32'(busy), 32'd0);
        md_op = 3'd5; rs_val = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        chk("mtlo.lo", lo, 32'h9ABC_DEF0);
        chk("mtlo.hi", hi, 32'h1234_5678);
        chk("mtlo.busy", 32'(busy), 32'd0);

        // Reserved opcode does nothing.
        start = 1'b1; md_op = 3'd6; rs_val = 32'h5555_5555; rt_val = 32'd9;
        tick();
        start = 1'b0;
        chk("rsvd.busy", 32'(busy), 32'd0);
        chk("rsvd.hi", hi, 32'h1234_5678);
        chk("rsvd.lo", lo, 32'h9ABC_DEF0);

        // Second start during BUSY is ignored: latency stays 5, result is 3*4.
        start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 2) begin
                start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
            end else begin
                start = 1'b0;
            end
            if (n == 3) begin
                chk("ign.hi_mid", hi, 32'h1234_5678);
                chk("ign.lo_mid", lo, 32'h9ABC_DEF0);
            end
            tick();
        end
        start = 1'b0;
        chk("ign.cycles", 32'(n), 32'd5);
        chk("ign.hi", hi, 32'd0);
        chk("ign.lo", lo, 32'd12);

        // Async reset during busy cycle 3 of a div.
        start = 1'b1; md_op = 3'd2; rs_val = 32'd50; rt_val = 32'd3;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("arst.pre_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.hi", hi, 32'd0);
        chk("arst.lo", lo, 32'd12 & 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("arst.after_busy", 32'(busy), 32'd0);
        chk("arst.after_lo", lo, 32'd0);
        run_op("post_rst", 3'd0, 32'd6, 32'd7, 5, 32'd0, 32'd42);

`ifdef MDU_CANCEL_EN
        // Cancel at busy cycle 2: nothing commits.
        start = 1'b1; md_op = 3'd1; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000;
        tick();
        start = 1'b0;
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel.busy", 32'(busy), 32'd0);
        chk("cancel.hi", hi, 32'd0);
        chk("cancel.lo", lo, 32'd42);
        repeat (6) tick();
        chk("cancel.hi_late", hi, 32'd0);
        chk("cancel.lo_late", lo, 32'd42);
        // Cancel in IDLE suppresses both arithmetic start and mtlo.
        start = 1'b1; cancel = 1'b1; md_op = 3'd5; rs_val = 32'hDEAD_BEEF;
        tick();
        md_op = 3'd0;
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("cancel.idle_busy", 32'(busy), 32'd0);
        chk("cancel.idle_lo", lo, 32'd42);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and owns the HI/LO registers.
- Models the fixed MDU latency with a down-counter and raises a stall request to the hazard unit while a D-stage MDU instruction must wait.
- Sits beside the E-stage ALU; its outputs feed the mfhi/mflo select mux and the PC/RegD enable logic.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYC, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is mult/multu/div/divu or mthi/mtlo, valid this cycle.
- md_op  in  3  operation code: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; others are reserved and ignored.
- rs_val  in  32  forwarded E-stage rs operand.
- rt_val  in  32  forwarded E-stage rt operand.
- d_md_use  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  arithmetic operation in flight.
- stall_req  out  1  hold PC/RegD and clear RegE this cycle.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (reset=0, async): state IDLE, counter=0, hi=0, lo=0, pending regs=0, busy=0, stall_req=0.
- States: IDLE and BUSY. busy = (state==BUSY).
- IDLE, start=1, arithmetic op:
  - Compute the 64-bit result combinationally and latch it into hi_pend/lo_pend at the edge.
  - Load counter with MULT_CYC or DIV_CYC; go to BUSY.
- BUSY:
  - Counter decrements every edge.
  - On the edge where counter goes 1->0: hi<=hi_pend, lo<=lo_pend, go to IDLE.
  - Net effect: busy is high for exactly N cycles after the start edge, and new hi/lo are visible in the first cycle busy=0.
- mthi/mtlo in IDLE: hi<=rs_val or lo<=rs_val at the next edge; no busy cycles.
- start=1 while BUSY: ignored (no state, counter, hi or lo change). The hazard unit makes this impossible in-system; the bench asserts it.
- stall_req = d_md_use & (busy | (start & md_op is MULT/MULTU/DIV/DIVU)). It is combinational, with no added latency.
- Arithmetic:
  - mult: signed 32x32->64.
  - multu: unsigned 32x32->64.
  - hi = product[63:32], lo = product[31:0].
  - div/divu: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero: hi/lo are left unchanged at completion, but busy still runs DIV_CYC cycles.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Reserved md_op with start=1: no effect.
- Reset asserted mid-operation: the operation is aborted immediately, everything returns to reset values, and the pending result is discarded.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds input cancel (1 bit), driven by the exception/flush logic.
  - cancel=1 in BUSY: go to IDLE at the next edge and clear the counter; hi/lo keep their pre-operation values.
  - cancel=1 in IDLE with start=1: start is suppressed, and mthi/mtlo are suppressed as well.
  - cancel has priority over start and over completion in the same cycle.
- Not defined: the port is absent and operations always run to completion.

Decomposition:
- Package mdu_pkg holds:
  - md_op localparams (MULT..MTLO);
  - the state encoding (IDLE, BUSY);
  - the counter width constant CNT_W=4.
- Sub-module mdu_arith:
  - purely combinational;
  - inputs md_op, rs_val, rt_val;
  - outputs 32-bit hi_res and lo_res plus a div_zero flag.
- mdu_ctrl keeps the FSM, counter, pending registers, HI/LO and stall logic.

Test Plan:
- Reset released, start mult rs=0xFFFFFFFF rt=2 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=-7 (0xFFFFFFF9) rt=2 -> busy=1 for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7 rt=0 -> hi/lo unchanged after 10 cycles.
- mult started, d_md_use=1 held -> stall_req=1 in the start cycle and for all 5 busy cycles, then 0 in the cycle busy falls.
- mthi rs=0x12345678 then mtlo rs=0x9ABCDEF0 in consecutive cycles -> hi/lo updated one edge later each, busy stays 0; a second start while BUSY leaves the counter and hi/lo untouched.
- reset driven low at busy cycle 3 of a div -> busy, hi, lo are 0 immediately (asynchronously); after release, a new mult completes normally.
- With MDU_CANCEL_EN: cancel at busy cycle 2 -> busy=0 next cycle and hi/lo equal to their pre-mult values.
